// File: rtl/arb_pkg.sv
// Shared types, mode encodings and helpers for the weighted round-robin lock arbiter.
package arb_pkg;

  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_WRR   = 1'b1;

  // Widest one-hot vector onehot2bin accepts.
  localparam int unsigned OH_MAX = 32;

  // Ceiling log2, used to size client indices.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Binary index of a one-hot vector; returns 0 for an all-zero input.
  function automatic int unsigned onehot2bin(input logic [OH_MAX-1:0] oh);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < OH_MAX; i++) begin
      if (oh[i]) r = r | i;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_wrr_lock_if.sv
// Client-side and upstream handshake bundle of the arbiter.
interface arb_wrr_lock_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned WW = 4
) ();
  import arb_pkg::*;

  localparam int unsigned IW = clog2(N);

  logic [N-1:0]    req_i;
  logic [N-1:0]    last_i;
  logic [N*WW-1:0] weight_i;
  logic            mode_i;
  logic [N-1:0]    ack_i;
  logic            req_o;
  logic            ack_o;
  logic [IW-1:0]   gnt_id_o;

  // Arbiter side.
  modport slave (
    input  req_i, last_i, weight_i, mode_i, ack_o,
    output ack_i, req_o, gnt_id_o
  );

  // Environment side: clients plus upstream sink.
  modport master (
    output req_i, last_i, weight_i, mode_i, ack_o,
    input  ack_i, req_o, gnt_id_o
  );

endinterface

// File: rtl/arb_rr_pick.sv
// Combinational rotating-priority picker: first request at or after the one-hot prio, wrapping.
module arb_rr_pick #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] prio,
  output logic [N-1:0] gnt
);

  logic [2*N-1:0] req2;
  logic [2*N-1:0] prio2;
  logic [2*N-1:0] gnt2;
  logic           carry;

  // Token enters at prio and ripples across a doubled request vector until a requester absorbs it.
  always_comb begin
    req2  = {req, req};
    prio2 = {{N{1'b0}}, prio};
    gnt2  = '0;
    carry = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      gnt2[i] = req2[i] & (carry | prio2[i]);
      carry   = (carry | prio2[i]) & ~req2[i];
    end
    gnt = gnt2[N-1:0] | gnt2[2*N-1:N];
  end

endmodule

// File: rtl/arb_wrr_lock.sv
// N-way weighted round-robin / fixed-priority arbiter with packet lock on a req/ack channel.
module arb_wrr_lock
  import arb_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned WW = 4
) (
  input logic          clk,
  input logic          rstn,
  arb_wrr_lock_if.slave bus
);

  localparam int unsigned IW = clog2(N);

  logic [N-1:0]  prio;
  logic          lock;
  logic [IW-1:0] lock_id;
  logic [WW-1:0] credit [N];

  logic [WW-1:0] wt_eff [N];
  logic [N-1:0]  elig;
  logic [N-1:0]  gnt_elig;
  logic [N-1:0]  gnt_req;
  logic [N-1:0]  sel_oh;
  logic          req_up;
  logic [IW-1:0] sel_id;
  logic          beat;
  logic          round_end;
  logic [WW-1:0] cred_new;

  // Effective weights (0 means 1) and clients still holding credit this round.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      wt_eff[k] = (bus.weight_i[k*WW +: WW] == '0) ? WW'(1) : bus.weight_i[k*WW +: WW];
      elig[k]   = bus.req_i[k] & (credit[k] != '0);
    end
  end

  arb_rr_pick #(.N(N)) u_pick_elig (.req(elig),      .prio(prio), .gnt(gnt_elig));
  arb_rr_pick #(.N(N)) u_pick_req  (.req(bus.req_i), .prio(prio), .gnt(gnt_req));

  // Choose the serviced client: lock first, then fixed priority or weighted round-robin.
  always_comb begin
    sel_oh = '0;
    req_up = 1'b0;
    if (lock) begin
      sel_oh = N'(1) << lock_id;
      req_up = bus.req_i[lock_id];
    end else if (bus.mode_i == ARB_MODE_FIXED) begin
      sel_oh = bus.req_i & (~bus.req_i + N'(1));
      req_up = |bus.req_i;
    end else begin
      sel_oh = (|elig) ? gnt_elig : gnt_req;
      req_up = |bus.req_i;
    end
    sel_id = IW'(onehot2bin(32'(sel_oh)));
  end

  // Credit bookkeeping for a completed packet; a client with no credit left marks the round end.
  always_comb begin
    beat      = req_up & bus.ack_o;
    round_end = (credit[sel_id] == '0);
    cred_new  = round_end ? (wt_eff[sel_id] - WW'(1)) : (credit[sel_id] - WW'(1));
  end

  // Zero-latency outputs; ack_i is also gated by reset so an aborted packet sees no ack.
  assign bus.req_o    = req_up;
  assign bus.gnt_id_o = sel_id;
  assign bus.ack_i    = sel_oh & {N{req_up & bus.ack_o & rstn}};

  // Lock, credit and priority state advance only on an accepted beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio    <= N'(1);
      lock    <= 1'b0;
      lock_id <= '0;
      for (int k = 0; k < N; k++) credit[k] <= '0;
    end else if (beat) begin
      if (!bus.last_i[sel_id]) begin
        lock    <= 1'b1;
        lock_id <= sel_id;
      end else begin
        lock <= 1'b0;
        if (bus.mode_i == ARB_MODE_WRR) begin
          if (round_end) begin
            for (int k = 0; k < N; k++) credit[k] <= wt_eff[k];
          end
          credit[sel_id] <= cred_new;
          prio <= (cred_new == '0) ? {sel_oh[N-2:0], sel_oh[N-1]} : sel_oh;
        end
      end
    end
  end

endmodule

// File: tb/tb_arb_wrr_lock.sv
// Directed and randomized bench for arb_wrr_lock with a rule-level reference model.
module tb_arb_wrr_lock;
  import arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned WW = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  arb_wrr_lock_if #(.N(N), .WW(WW)) bus ();

  arb_wrr_lock #(.N(N), .WW(WW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference state kept as plain integers.
  int m_prio;
  bit m_lock;
  int m_lock_id;
  int m_credit [N];

  bit e_req;
  int e_sel;

  int t1_ack [5] = '{1, 2, 4, 8, 1};
  int t1_gnt [5] = '{0, 1, 2, 3, 0};
  int t2_gnt [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prio    = 0;
    m_lock    = 0;
    m_lock_id = 0;
    for (int k = 0; k < N; k++) m_credit[k] = 0;
  endtask

  function automatic int wt(input int k);
    int w;
    w = int'(bus.weight_i[k*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  // Who should be selected right now, and whether the upstream request is up.
  task automatic model_eval();
    bit found;
    e_sel = 0;
    e_req = 0;
    found = 0;
    if (m_lock) begin
      e_sel = m_lock_id;
      e_req = bus.req_i[m_lock_id];
    end else if (bus.mode_i == 1'b0) begin
      for (int k = N - 1; k >= 0; k--) if (bus.req_i[k]) e_sel = k;
      e_req = |bus.req_i;
    end else begin
      for (int j = 0; j < N; j++) begin
        int idx;
        idx = (m_prio + j) % N;
        if (!found && bus.req_i[idx] && m_credit[idx] > 0) begin
          e_sel = idx;
          found = 1;
        end
      end
      for (int j = 0; j < N; j++) begin
        int idx;
        idx = (m_prio + j) % N;
        if (!found && bus.req_i[idx]) begin
          e_sel = idx;
          found = 1;
        end
      end
      e_req = |bus.req_i;
    end
  endtask

  // Compare outputs against the model, then advance one clock with the same inputs.
  task automatic cycle();
    int exp_ack;
    model_eval();
    exp_ack = (rstn && e_req && bus.ack_o) ? (1 << e_sel) : 0;
    check("ack_i", 32'(bus.ack_i), 32'(exp_ack));
    check("req_o", 32'(bus.req_o), 32'(e_req));
    if (e_req) check("gnt_id", 32'(bus.gnt_id_o), 32'(e_sel));
    @(posedge clk);
    if (rstn && e_req && bus.ack_o) begin
      if (!bus.last_i[e_sel]) begin
        m_lock    = 1;
        m_lock_id = e_sel;
      end else begin
        m_lock = 0;
        if (bus.mode_i == 1'b1) begin
          if (m_credit[e_sel] == 0) begin
            for (int k = 0; k < N; k++) m_credit[k] = wt(k);
          end
          m_credit[e_sel] = m_credit[e_sel] - 1;
          m_prio = (m_credit[e_sel] == 0) ? (e_sel + 1) % N : e_sel;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] last, input logic ack);
    bus.req_i  = req;
    bus.last_i = last;
    bus.ack_o  = ack;
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    model_reset();
    #1;
    check("ack_in_reset", 32'(bus.ack_i), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn         = 1'b0;
    bus.req_i    = '0;
    bus.last_i   = '0;
    bus.ack_o    = 1'b0;
    bus.mode_i   = 1'b1;
    bus.weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    model_reset();
    #1;
    check("rst_ack", 32'(bus.ack_i), 32'd0);
    check("rst_req_o", 32'(bus.req_o), 32'd0);
    check("rst_gnt_idle", 32'(bus.gnt_id_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Equal weights rotate through all four clients.
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 4'b1111, 1'b1);
      check("t1_ack", 32'(bus.ack_i), 32'(t1_ack[i]));
      check("t1_gnt", 32'(bus.gnt_id_o), 32'(t1_gnt[i]));
      cycle();
    end

    // Weight 3 on client 0 yields three packets per round.
    apply_reset();
    bus.weight_i = {4'd1, 4'd1, 4'd1, 4'd3};
    for (int i = 0; i < 8; i++) begin
      drive(4'b0011, 4'b1111, 1'b1);
      check("t2_gnt", 32'(bus.gnt_id_o), 32'(t2_gnt[i]));
      cycle();
    end

    // Four-beat packet from client 2 holds the channel, then client 3 is next.
    apply_reset();
    bus.weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    drive(4'b1111, 4'b1111, 1'b1); cycle();
    drive(4'b1111, 4'b1111, 1'b1); cycle();
    for (int i = 0; i < 4; i++) begin
      drive(4'b1111, (i == 3) ? 4'b1111 : 4'b1011, 1'b1);
      check("t3_lock_ack", 32'(bus.ack_i), 32'h4);
      cycle();
    end
    drive(4'b1111, 4'b1111, 1'b1);
    check("t3_next", 32'(bus.ack_i), 32'h8);
    cycle();

    // Upstream stall during a locked packet.
    apply_reset();
    drive(4'b1111, 4'b0000, 1'b1); cycle();
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 4'b0000, 1'b0);
      check("t4_stall_ack", 32'(bus.ack_i), 32'd0);
      cycle();
    end
    drive(4'b1111, 4'b0001, 1'b1);
    check("t4_resume", 32'(bus.ack_i), 32'h1);
    cycle();

    // Fixed priority, then switch to round-robin while locked.
    apply_reset();
    bus.mode_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'b1010, 4'b0000, 1'b1);
      check("t5_fixed", 32'(bus.ack_i), 32'h2);
      cycle();
    end
    bus.mode_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(4'b1010, (i == 2) ? 4'b0010 : 4'b0000, 1'b1);
      check("t5_locked", 32'(bus.ack_i), 32'h2);
      cycle();
    end
    drive(4'b1010, 4'b1111, 1'b1);
    check("t5_rr_after", 32'(bus.ack_i), 32'h8);
    cycle();

    // Reset in the middle of a locked packet.
    apply_reset();
    drive(4'b1111, 4'b1111, 1'b1); cycle();
    drive(4'b1111, 4'b0000, 1'b1); cycle();
    bus.req_i = 4'b1111;
    bus.ack_o = 1'b1;
    apply_reset();
    drive(4'b1111, 4'b1111, 1'b1);
    check("t6_first", 32'(bus.gnt_id_o), 32'd0);
    cycle();
    drive(4'b1111, 4'b1111, 1'b1);
    check("t6_second", 32'(bus.gnt_id_o), 32'd1);
    cycle();

    // Randomized traffic against the model.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] r;
      logic [N-1:0] l;
      if (i % 200 == 0) begin
        for (int k = 0; k < N; k++) bus.weight_i[k*WW +: WW] = WW'($urandom_range(0, 3));
      end
      if (!m_lock && $urandom_range(0, 49) == 0) bus.mode_i = ~bus.mode_i;
      r = N'($urandom);
      for (int k = 0; k < N; k++) l[k] = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 399) == 0) begin
        rstn = 1'b0;
        model_reset();
      end else begin
        rstn = 1'b1;
      end
      drive(r, l, ($urandom_range(0, 3) != 0));
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
